poly_chord_mixer: RTL and testbench

- Parametrised N-voice sample mixer; successor to the fixed three-voice chord path.
- Sits between NUM_VOICES note_player instances and the codec sample interface.
- Per codec request it collects one signed sample from each active voice, with a timeout for missing voices.
- Sums voices sequentially, normalises, optionally saturates, and presents one sample with a ready strobe.

---
 rtl/poly_chord_mixer.sv | 181 ++++++++++++++++++
 tb/tb_poly_chord_mixer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_chord_mixer.sv
// poly_chord_mixer: N-voice sample mixer between note players and the codec.
// On each codec request it collects one signed sample per active voice
// (zero-filling voices that miss the timeout window), sums them one voice per
// cycle, normalises the sum and presents it with a one-cycle ready strobe.
// Optional feature macro: MIX_SATURATE_EN (shift by MIX_SHIFT and clamp);
// without it the sum is shifted by clog2(NUM_VOICES) and cannot overflow.
module poly_chord_mixer #(
  parameter int NUM_VOICES  = 3,
  parameter int SAMPLE_W    = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int MIX_SHIFT   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play_enable,
  input  logic [NUM_VOICES-1:0]          voice_active,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_sample_valid,
  input  logic                           generate_next_sample,
  output logic [SAMPLE_W-1:0]            sample_out,
  output logic                           new_sample_ready,
  output logic [NUM_VOICES-1:0]          voice_timeout,
  output logic                           overrun
);

  localparam int CW    = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + CW;
  localparam int TW    = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(NUM_VOICES - 1);

  // Elaboration-time guards on the legal parameter ranges.
  if (NUM_VOICES < 2 || NUM_VOICES > 8) begin : g_bad_voices
    $error("poly_chord_mixer: NUM_VOICES must be 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("poly_chord_mixer: TIMEOUT_CYC must be at least 2");
  end
  if (MIX_SHIFT < 0 || MIX_SHIFT >= ACC_W) begin : g_bad_shift
    $error("poly_chord_mixer: MIX_SHIFT out of range");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, SUM, OUT} state_t;

  state_t                      r_state, w_state_next;
  logic [NUM_VOICES-1:0]       r_pending;
  logic signed [SAMPLE_W-1:0]  r_samples [NUM_VOICES];
  logic [TW-1:0]               r_to_cnt;
  logic [CW-1:0]               r_idx;
  logic signed [ACC_W-1:0]     r_acc;
  logic [SAMPLE_W-1:0]         r_sample_out;
  logic [NUM_VOICES-1:0]       r_voice_timeout;
  logic                        r_overrun;

  logic                        w_start;
  logic [NUM_VOICES-1:0]       w_capture;
  logic                        w_timeout_hit;
  logic [NUM_VOICES-1:0]       w_zero_fill;
  logic signed [SAMPLE_W-1:0]  w_cur;
  logic signed [ACC_W-1:0]     w_ext;
  logic signed [ACC_W-1:0]     w_acc_sum;
  logic [SAMPLE_W-1:0]         w_norm;

  assign w_start       = (r_state == IDLE) && generate_next_sample;
  assign w_timeout_hit = (r_state == COLLECT) && (r_pending != '0) && (r_to_cnt == TO_LAST);
  assign w_zero_fill   = w_timeout_hit ? (r_pending & ~voice_sample_valid) : '0;
  assign w_cur         = r_samples[r_idx];
  assign w_ext         = w_cur;  // signed source: sign-extends into the accumulator width
  assign w_acc_sum     = r_acc + w_ext;

  // Which voices latch their sample this cycle: only pending ones, first strobe wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    w_capture = '0;
    if (w_start && play_enable) begin
      w_capture = voice_active & voice_sample_valid;
    end else if (r_state == COLLECT) begin
      w_capture = r_pending & voice_sample_valid;
    end
  end

  // Normalise the final accumulator value into an output sample.
`ifdef MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(CW+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(CW+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};
  logic signed [ACC_W-1:0] w_shifted;
  assign w_shifted = w_acc_sum >>> MIX_SHIFT;

  always_comb begin
    w_norm = w_shifted[SAMPLE_W-1:0];
    if (w_shifted > SAT_MAX) begin
      w_norm = SAT_MAX[SAMPLE_W-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_norm = SAT_MIN[SAMPLE_W-1:0];
    end
  end
`else
  // Shifting by clog2(NUM_VOICES) then truncating is just the top SAMPLE_W bits.
  assign w_norm = w_acc_sum[ACC_W-1:CW];
`endif

  // Next-state selection for the request / collect / sum / output sequence.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (generate_next_sample) w_state_next = play_enable ? COLLECT : SUM;
      COLLECT: if ((r_pending == '0) || w_timeout_hit) w_state_next = SUM;
      SUM:     if (r_idx == IDX_LAST) w_state_next = OUT;
      OUT:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every register sees pre-edge values.
      r_state <= w_state_next;
    end
  end

  // Per-voice sample latches: cleared on every request, then filled by captures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the latch array is a handful of flops, not a RAM, so it is reset like any other register.
      for (int i = 0; i < NUM_VOICES; i++) r_samples[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (w_start) begin
          r_samples[i] <= w_capture[i] ? voice_sample[i*SAMPLE_W +: SAMPLE_W] : '0;
        end else if (w_capture[i]) begin
          r_samples[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
        end else if (w_zero_fill[i]) begin
          r_samples[i] <= '0;
        end
      end
    end
  end

  // Control and datapath registers: pending mask, timeout, accumulator, outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending       <= '0;
      r_to_cnt        <= '0;
      r_idx           <= '0;
      r_acc           <= '0;
      r_sample_out    <= '0;
      r_voice_timeout <= '0;
      r_overrun       <= 1'b0;
    end else begin
      if (w_start) begin
        r_pending       <= play_enable ? (voice_active & ~voice_sample_valid) : '0;
        r_to_cnt        <= '0;
        r_voice_timeout <= '0;
      end else if (r_state == COLLECT) begin
        r_pending <= w_timeout_hit ? '0 : (r_pending & ~voice_sample_valid);
        r_to_cnt  <= r_to_cnt + 1'b1;
        if (w_timeout_hit) r_voice_timeout <= w_zero_fill;
      end

      if (w_state_next == SUM && r_state != SUM) begin
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == SUM) begin
        r_acc <= w_acc_sum;
        r_idx <= r_idx + 1'b1;
        if (r_idx == IDX_LAST) r_sample_out <= w_norm;
      end

      if (generate_next_sample && r_state != IDLE) r_overrun <= 1'b1;
    end
  end

  assign sample_out       = r_sample_out;
  assign new_sample_ready = (r_state == OUT);
  assign voice_timeout    = r_voice_timeout;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_poly_chord_mixer.sv
// Testbench for poly_chord_mixer: randomized requests with a scoreboard fed by
// an arithmetic reference model and drained by an independent strobe monitor.
module tb_poly_chord_mixer;

  localparam int N   = 3;
  localparam int SW  = 16;
  localparam int TO  = 16;
  localparam int MSH = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            play_enable = 1'b0;
  logic [N-1:0]    voice_active = '0;
  logic [N*SW-1:0] voice_sample = '0;
  logic [N-1:0]    voice_sample_valid = '0;
  logic            generate_next_sample = 1'b0;
  logic [SW-1:0]   sample_out;
  logic            new_sample_ready;
  logic [N-1:0]    voice_timeout;
  logic            overrun;

  poly_chord_mixer #(
    .NUM_VOICES(N), .SAMPLE_W(SW), .TIMEOUT_CYC(TO), .MIX_SHIFT(MSH)
  ) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable),
    .voice_active(voice_active), .voice_sample(voice_sample),
    .voice_sample_valid(voice_sample_valid),
    .generate_next_sample(generate_next_sample),
    .sample_out(sample_out), .new_sample_ready(new_sample_ready),
    .voice_timeout(voice_timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SW-1:0] smp;
    logic [N-1:0]  to;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          strobes = 0;
  int unsigned last_strobe_cyc = 0;
  int unsigned req_cyc = 0;

  int            g_dly[N];
  logic [SW-1:0] g_val[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer mix of the delivered samples, floor shift, optional clamp.
  function automatic logic [SW-1:0] model(input int sum);
    int r;
`ifdef MIX_SATURATE_EN
    r = sum >>> MSH;
    if (r > (2**(SW-1)) - 1) r = (2**(SW-1)) - 1;
    if (r < -(2**(SW-1)))    r = -(2**(SW-1));
`else
    r = sum >>> $clog2(N);
`endif
    return r[SW-1:0];
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (new_sample_ready === 1'b1) begin
        strobes++;
        last_strobe_cyc = cyc;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: actual=strobe required=none (t=%0t)", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("sample_out", 32'(sample_out), 32'(mon_e.smp));
          check("voice_timeout", 32'(voice_timeout), 32'(mon_e.to));
        end
      end
    end
  end

  // One codec request. Voice i delivers g_val[i] g_dly[i] cycles after the request
  // (-1 = silent). With chaos set, inactive/already-delivered voices get junk
  // strobes and play_enable / voice_active wander after the request cycle.
  task automatic run_req(input logic pe, input logic [N-1:0] act, input int dup_at, input bit chaos);
    int          sum = 0;
    logic [N-1:0] to_exp = '0;
    exp_t        e;
    int          start;
    logic [31:0] rnd;
    for (int i = 0; i < N; i++) begin
      if (pe && act[i]) begin
        if (g_dly[i] >= 0) sum += int'($signed(g_val[i]));
        else               to_exp[i] = 1'b1;
      end
    end
    e.smp = pe ? model(sum) : '0;
    e.to  = to_exp;
    sb_q.push_back(e);
    start = strobes;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) req_cyc = cyc;
      if (c == 2) check("timeout_cleared_by_request", 32'(voice_timeout), 32'd0);
      rnd = $urandom;
      generate_next_sample = (c == 0) || (c == dup_at);
      play_enable  = (c == 0 || !chaos) ? pe : rnd[0];
      voice_active = (c == 0 || !chaos) ? act : rnd[N:1];
      voice_sample_valid = '0;
      for (int i = 0; i < N; i++) begin
        rnd = $urandom;
        voice_sample[i*SW +: SW] = rnd[SW-1:0];
        if (c == g_dly[i]) begin
          voice_sample_valid[i] = 1'b1;
          voice_sample[i*SW +: SW] = g_val[i];
        end else if (chaos && rnd[17:16] == 2'b00 &&
                     (!act[i] || (g_dly[i] >= 0 && c > g_dly[i]))) begin
          voice_sample_valid[i] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    generate_next_sample = 1'b0;
    voice_sample_valid = '0;
    play_enable = pe;
    voice_active = act;
    for (int k = 0; k < 100 && strobes == start; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("strobes_per_request", 32'(strobes - start), 32'd1);
  endtask

  task automatic set_voices(input int d0, input int d1, input int d2,
                            input logic [SW-1:0] v0, input logic [SW-1:0] v1, input logic [SW-1:0] v2);
    g_dly[0] = d0; g_dly[1] = d1; g_dly[2] = d2;
    g_val[0] = v0; g_val[1] = v1; g_val[2] = v2;
  endtask

  initial begin
    int start;
    logic [31:0] rnd;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sample_out", 32'(sample_out), 32'd0);
    check("reset_ready", 32'(new_sample_ready), 32'd0);
    check("reset_timeout", 32'(voice_timeout), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic mix, all voices in the request cycle: 4-edge latency, 0x3000.
    set_voices(0, 0, 0, 16'h4000, 16'h4000, 16'h4000);
    run_req(1'b1, 3'b111, -1, 1'b0);
    check("latency_immediate", last_strobe_cyc - req_cyc, 32'(N + 1));

    // Negative mix.
    set_voices(0, 0, 0, 16'h8000, 16'h8000, 16'h0000);
    run_req(1'b1, 3'b111, -1, 1'b0);

    // Timeout: voice 2 silent.
    set_voices(0, 1, -1, 16'h1000, 16'h1000, 16'h7777);
    run_req(1'b1, 3'b111, -1, 1'b0);

    // Masked: only voice 1 active; the others strobe but must be ignored.
    set_voices(0, 0, 0, 16'h1234, 16'h2000, 16'h4321);
    run_req(1'b1, 3'b010, -1, 1'b0);

    // Disabled: zero result with strobe.
    set_voices(0, 0, 0, 16'h4000, 16'h4000, 16'h4000);
    run_req(1'b0, 3'b111, -1, 1'b0);

    // No voices active.
    run_req(1'b1, 3'b000, -1, 1'b0);

    // Last pending bit cleared 3 edges after the request -> strobe N+1 edges later.
    set_voices(0, 2, 3, 16'h0100, 16'hFF00, 16'h0300);
    run_req(1'b1, 3'b111, -1, 1'b0);
    check("latency_collect", last_strobe_cyc - req_cyc, 32'(3 + N + 1));

    // play_enable wanders during COLLECT: mix still completes.
    set_voices(2, 5, 8, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_req(1'b1, 3'b111, -1, 1'b1);

    // Randomized requests.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        rnd = $urandom;
        g_dly[i] = (rnd[2:0] == 3'd0) ? -1 : int'(rnd[6:3] % 11);
        g_val[i] = rnd[31:16];
      end
      rnd = $urandom;
      run_req(rnd[2:0] != 3'd0, rnd[6:4], -1, 1'b1);
    end

    // Overrun: second request while in SUM; only one strobe.
    check("overrun_before", 32'(overrun), 32'd0);
    set_voices(0, 0, 0, 16'h4000, 16'h4000, 16'h4000);
    run_req(1'b1, 3'b111, 2, 1'b0);
    check("overrun_after", 32'(overrun), 32'd1);

    // Reset during COLLECT: outputs clear at once, no strobe afterwards.
    @(posedge clk);
    #1;
    generate_next_sample = 1'b1;
    play_enable = 1'b1;
    voice_active = 3'b111;
    voice_sample_valid = 3'b011;
    voice_sample = {16'h0000, 16'h1111, 16'h2222};
    @(posedge clk);
    #1;
    generate_next_sample = 1'b0;
    voice_sample_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_sample_out", 32'(sample_out), 32'd0);
    check("midreset_ready", 32'(new_sample_ready), 32'd0);
    check("midreset_timeout", 32'(voice_timeout), 32'd0);
    check("midreset_overrun", 32'(overrun), 32'd0);
    sb_q.delete();
    start = strobes;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no_strobe_after_reset", 32'(strobes - start), 32'd0);
    check("sample_out_after_reset", 32'(sample_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
